// File: rtl/intidct_2d.sv
// intidct_2d: 8x8 inverse integer DCT (HEVC 8-point kernel) with a row pass into a transpose buffer, then a column pass.
// Optional macro INTIDCT_SAT_FLAG_EN adds a sticky per-block saturation flag output (sat_flag).
module intidct_2d #(
    parameter int IN_WIDTH  = 16,
    parameter int INT_WIDTH = 16,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT1    = 7,
    parameter int SHIFT2    = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0][IN_WIDTH-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0][OUT_WIDTH-1:0] out_data,
    output logic                      out_last,
    output logic                      busy
`ifdef INTIDCT_SAT_FLAG_EN
    ,
    output logic                      sat_flag
`endif
);

    // Worst-case |sum| is 479 * 2^(W-1); ten guard bits cover that plus the rounding offset.
    localparam int ACC_W = ((IN_WIDTH > INT_WIDTH) ? IN_WIDTH : INT_WIDTH) + 10;

    localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] C18 = ACC_W'(18);
    localparam logic signed [ACC_W-1:0] C36 = ACC_W'(36);
    localparam logic signed [ACC_W-1:0] C50 = ACC_W'(50);
    localparam logic signed [ACC_W-1:0] C64 = ACC_W'(64);
    localparam logic signed [ACC_W-1:0] C75 = ACC_W'(75);
    localparam logic signed [ACC_W-1:0] C83 = ACC_W'(83);
    localparam logic signed [ACC_W-1:0] C89 = ACC_W'(89);

    typedef logic [7:0][ACC_W-1:0]     acc_vec_t;
    typedef logic [7:0][INT_WIDTH-1:0] int_vec_t;
    typedef logic [7:0][OUT_WIDTH-1:0] out_vec_t;
    typedef enum logic [1:0] {S_LOAD, S_COL, S_OUT} state_t;

    function automatic acc_vec_t kernel(input acc_vec_t v);
        logic signed [ACC_W-1:0] x [8];
        logic signed [ACC_W-1:0] ea, eb, ea2, eb2;
        logic signed [ACC_W-1:0] e0, e1, e2, e3, o0, o1, o2, o3;
        acc_vec_t u;
        for (int k = 0; k < 8; k++) begin
            x[k] = $signed(v[k]);
        end
        ea  = C64 * (x[0] + x[4]);
        ea2 = C64 * (x[0] - x[4]);
        eb  = C83 * x[2] + C36 * x[6];
        eb2 = C36 * x[2] - C83 * x[6];
        e0  = ea + eb;
        e1  = ea2 + eb2;
        e2  = ea2 - eb2;
        e3  = ea - eb;
        o0  = C89 * x[1] + C75 * x[3] + C50 * x[5] + C18 * x[7];
        o1  = C75 * x[1] - C18 * x[3] - C89 * x[5] - C50 * x[7];
        o2  = C50 * x[1] - C89 * x[3] + C18 * x[5] + C75 * x[7];
        o3  = C18 * x[1] - C50 * x[3] + C75 * x[5] - C89 * x[7];
        u[0] = e0 + o0;
        u[7] = e0 - o0;
        u[1] = e1 + o1;
        u[6] = e1 - o1;
        u[2] = e2 + o2;
        u[5] = e2 - o2;
        u[3] = e3 + o3;
        u[4] = e3 - o3;
        return u;
    endfunction

    function automatic logic signed [ACC_W-1:0] rnd(input logic signed [ACC_W-1:0] a, input int sh);
        return (a + (ONE <<< (sh - 1))) >>> sh;
    endfunction

    function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W-1:0] a, input int w);
        logic signed [ACC_W-1:0] hi, lo;
        hi = (ONE <<< (w - 1)) - ONE;
        lo = -hi - ONE;
        if (a > hi) begin
            return hi;
        end else if (a < lo) begin
            return lo;
        end else begin
            return a;
        end
    endfunction

    function automatic int_vec_t pass1(input acc_vec_t v);
        acc_vec_t u;
        int_vec_t res;
        u = kernel(v);
        for (int k = 0; k < 8; k++) begin
            res[k] = INT_WIDTH'(clamp(rnd($signed(u[k]), SHIFT1), INT_WIDTH));
        end
        return res;
    endfunction

    function automatic out_vec_t pass2(input acc_vec_t v);
        acc_vec_t u;
        out_vec_t res;
        u = kernel(v);
        for (int k = 0; k < 8; k++) begin
            res[k] = OUT_WIDTH'(clamp(rnd($signed(u[k]), SHIFT2), OUT_WIDTH));
        end
        return res;
    endfunction

`ifdef INTIDCT_SAT_FLAG_EN
    function automatic logic ovf(input acc_vec_t v, input int sh, input int w);
        acc_vec_t u;
        logic f;
        u = kernel(v);
        f = 1'b0;
        for (int k = 0; k < 8; k++) begin
            f |= (rnd($signed(u[k]), sh) != clamp(rnd($signed(u[k]), sh), w));
        end
        return f;
    endfunction
`endif

    state_t     r_state;
    logic [2:0] r_row;
    logic [2:0] r_col;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       r_out_last;
    logic       r_busy;
    out_vec_t   r_out_data;
    int_vec_t   r_buf [8];
    acc_vec_t   w_row_in;
    acc_vec_t   w_col_in;
    int_vec_t   w_row_p1;
    out_vec_t   w_col_p2;
    logic       w_row_hs;

    // Sign-extend the incoming row and gather the current buffer column.
    always_comb begin
        w_row_in = '0;
        w_col_in = '0;
        for (int k = 0; k < 8; k++) begin
            w_row_in[k] = ACC_W'($signed(in_data[k]));
            w_col_in[k] = ACC_W'($signed(r_buf[k][r_col]));
        end
    end

    assign w_row_p1 = pass1(w_row_in);
    assign w_col_p2 = pass2(w_col_in);
    assign w_row_hs = (r_state == S_LOAD) && in_valid && r_in_ready;

`ifdef INTIDCT_SAT_FLAG_EN
    logic r_sat;
    logic w_p1_ovf;
    logic w_p2_ovf;
    assign w_p1_ovf = ovf(w_row_in, SHIFT1, INT_WIDTH);
    assign w_p2_ovf = ovf(w_col_in, SHIFT2, OUT_WIDTH);
    assign sat_flag = r_sat;
`endif

    // Transpose buffer: pass-1 rows land here; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_row_hs && !rst) begin
            r_buf[r_row] <= w_row_p1;
        end
    end

    // Control FSM: load 8 rows, then alternate COL (compute) and OUT (hold until taken).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_row       <= 3'd0;
            r_col       <= 3'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_out_data  <= '0;
`ifdef INTIDCT_SAT_FLAG_EN
            r_sat       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_row_hs) begin
                        r_busy <= 1'b1;
`ifdef INTIDCT_SAT_FLAG_EN
                        r_sat  <= r_sat | w_p1_ovf;
`endif
                        if (r_row == 3'd7) begin
                            r_row      <= 3'd0;
                            r_in_ready <= 1'b0;
                            r_state    <= S_COL;
                        end else begin
                            r_row <= r_row + 3'd1;
                        end
                    end
                end
                S_COL: begin
                    r_out_data  <= w_col_p2;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_col == 3'd7);
                    r_state     <= S_OUT;
`ifdef INTIDCT_SAT_FLAG_EN
                    r_sat       <= r_sat | w_p2_ovf;
`endif
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_col      <= 3'd0;
                            r_state    <= S_LOAD;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
`ifdef INTIDCT_SAT_FLAG_EN
                            r_sat      <= 1'b0;
`endif
                        end else begin
                            r_col   <= r_col + 3'd1;
                            r_state <= S_COL;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_intidct_2d.sv
// Scoreboard bench for intidct_2d: a matrix-form reference model pushes expected columns; a monitor pops and compares.
`timescale 1ns/1ps
module tb_intidct_2d;
    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [7:0][15:0] in_data, out_data;
`ifdef INTIDCT_SAT_FLAG_EN
    logic sat_flag;
`endif

    always #5 clk = ~clk;

    intidct_2d dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
`ifdef INTIDCT_SAT_FLAG_EN
        , .sat_flag(sat_flag)
`endif
    );

    typedef struct packed {
        logic [7:0][15:0] data;
        logic             last;
        logic             sat;
    } exp_t;

    exp_t sb[$];

    // HEVC 8-point basis: M[k][n] is the weight of coefficient k on sample n.
    int M[8][8] = '{
        '{64,  64,  64,  64,  64,  64,  64,  64},
        '{89,  75,  50,  18, -18, -50, -75, -89},
        '{83,  36, -36, -83, -83, -36,  36,  83},
        '{75, -18, -89, -50,  50,  89,  18, -75},
        '{64, -64, -64,  64,  64, -64, -64,  64},
        '{50, -89,  18,  75, -75, -18,  89, -50},
        '{36, -83,  83, -36, -36,  83, -83,  36},
        '{18, -50,  75, -89,  89, -75,  50, -18}
    };

    int blk[8][8];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs8_cyc = 0;
    bit lat_arm = 1'b0;
    int rdy_mode = 0;
    int hold_cnt = 0;
    int col_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic longint rs(input longint s, input int sh, inout bit sat);
        longint r;
        r = (s + (longint'(1) <<< (sh - 1))) >>> sh;
        if (r > 32767) begin
            r = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            sat = 1'b1;
        end
        return r;
    endfunction

    // Reference: T = round(Y*M, 7) saturated, X = round(M^T*T, 12) saturated, emitted column by column.
    task automatic push_expected();
        longint t[8][8];
        longint x[8];
        longint acc;
        bit s;
        exp_t e;
        s = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int n = 0; n < 8; n++) begin
                acc = 0;
                for (int k = 0; k < 8; k++) acc += longint'(blk[r][k]) * M[k][n];
                t[r][n] = rs(acc, 7, s);
            end
        for (int j = 0; j < 8; j++) begin
            for (int m = 0; m < 8; m++) begin
                acc = 0;
                for (int i = 0; i < 8; i++) acc += t[i][j] * M[i][m];
                x[m] = rs(acc, 12, s);
                e.data[m] = 16'(x[m]);
            end
            e.last = (j == 7);
            e.sat  = s;
            sb.push_back(e);
        end
    endtask

    task automatic send_block(input int nrows, input int gap_pct, input bit arm_lat);
        int r;
        int guard;
        r = 0;
        guard = 0;
        while (r < nrows && guard < 3000) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            for (int k = 0; k < 8; k++) in_data[k] = 16'(blk[r][k]);
            @(negedge clk);
            if (in_valid && in_ready) begin
                r++;
                if (r == 8) begin
                    push_expected();
                    if (arm_lat) begin
                        hs8_cyc = cyc;
                        lat_arm = 1'b1;
                    end
                end
            end
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rows_accepted", 128'(r), 128'(nrows));
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("drain_queue_empty", 128'(sb.size()), 128'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic set_const(input int v00, input int row0);
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) blk[r][k] = (r == 0) ? row0 : 0;
        blk[0][0] = v00;
    endtask

    task automatic set_rand();
        int mode;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) begin
                mode = int'($urandom_range(0, 3));
                case (mode)
                    0: blk[r][k] = int'($urandom_range(0, 255)) - 128;
                    1: blk[r][k] = int'($urandom_range(0, 4095)) - 2048;
                    2: blk[r][k] = int'($urandom_range(0, 65535)) - 32768;
                    default: blk[r][k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768 : 0;
                endcase
            end
    endtask

    // Downstream ready generator.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 99) < 60);
                default: begin
                    if (out_valid && col_cnt == 3 && hold_cnt < 5) begin
                        out_ready = 1'b0;
                        hold_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: compares every output handshake against the scoreboard and checks hold/latency rules.
    initial begin
        exp_t e;
        bit hold_prev;
        bit after_last;
        logic [7:0][15:0] prev_data;
        logic prev_last;
        hold_prev = 1'b0;
        after_last = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
                after_last = 1'b0;
                col_cnt = 0;
            end else begin
                if (after_last) begin
                    chk("in_ready_after_last", 128'(in_ready), 128'(1));
                    chk("busy_after_last", 128'(busy), 128'(0));
                    after_last = 1'b0;
                end
                if (hold_prev) begin
                    chk("held_valid", 128'(out_valid), 128'(1));
                    chk("held_data", 128'(out_data), 128'(prev_data));
                    chk("held_last", 128'(out_last), 128'(prev_last));
                end
                if (lat_arm && out_valid) begin
                    chk("first_valid_latency", 128'(cyc - hs8_cyc), 128'(2));
                    lat_arm = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output got=%0h exp=none", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("column_data", 128'(out_data), 128'(e.data));
                        chk("column_last", 128'(out_last), 128'(e.last));
                        chk("busy_while_out", 128'(busy), 128'(1));
`ifdef INTIDCT_SAT_FLAG_EN
                        chk("sat_flag", 128'(sat_flag), 128'(e.sat));
`endif
                        col_cnt = (col_cnt + 1) % 8;
                        if (e.last) after_last = 1'b1;
                    end
                end
                hold_prev = out_valid && !out_ready;
                prev_data = out_data;
                prev_last = out_last;
            end
        end
    end

    initial begin
        #800000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out_last", 128'(out_last), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_out_data", 128'(out_data), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // DC block with first-output latency check
        set_const(64, 0);
        send_block(8, 0, 1'b1);
        wait_drain();

        // all zeros
        set_const(0, 0);
        send_block(8, 0, 1'b0);
        wait_drain();

        // saturating block followed by a clean one
        set_const(32767, 32767);
        send_block(8, 0, 1'b0);
        wait_drain();
        set_const(64, 0);
        send_block(8, 0, 1'b0);
        wait_drain();

        // backpressure on column 3
        rdy_mode = 2;
        hold_cnt = 0;
        set_const(64, 0);
        send_block(8, 0, 1'b0);
        wait_drain();
        chk("backpressure_cycles", 128'(hold_cnt), 128'(5));
        rdy_mode = 0;

        // reset mid-load
        set_rand();
        send_block(4, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_in_ready", 128'(in_ready), 128'(1));
        chk("midreset_busy", 128'(busy), 128'(0));
        begin
            int seen;
            seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("midreset_no_valid", 128'(seen), 128'(0));
        end
        set_const(64, 0);
        send_block(8, 0, 1'b0);
        wait_drain();

        // randomized blocks with random in_valid gaps and out_ready
        rdy_mode = 1;
        for (int b = 0; b < 200; b++) begin
            set_rand();
            send_block(8, 30, 1'b0);
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
